// File: rtl/metronome_sequencer_pkg.sv
// rtl/metronome_sequencer_pkg.sv - shared types and tempo limits for the metronome beat path
package metronome_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef logic [7:0] bpm_t;

    localparam bpm_t BPM_MIN     = 8'd40;
    localparam bpm_t BPM_MAX     = 8'd240;
    localparam bpm_t BPM_DEFAULT = 8'd60;

    // Largest time signature numerator offered by the UI.
    localparam int MAX_BEATS = 8;

    function automatic logic [3:0] bar_len_of(input logic [3:0] beats);
        return (beats == 4'd0) ? 4'd1 : beats;
    endfunction

endpackage

// File: rtl/metronome_sequencer_if.sv
// rtl/metronome_sequencer_if.sv - control/status bundle between the UI side and the sequencer
interface metronome_sequencer_if;
    import metronome_pkg::*;

    logic       i_start_stop;
    logic       i_tempo_up;
    logic       i_tempo_down;
    logic [3:0] i_beats_per_bar;
    logic       i_beat_tick;
    bpm_t       o_bpm_out;
    logic       o_div_run;
    logic       o_running;
    logic [3:0] o_beat_idx;
    logic       o_beep;
    logic       o_accent;

    modport master (
        output i_start_stop, i_tempo_up, i_tempo_down, i_beats_per_bar, i_beat_tick,
        input  o_bpm_out, o_div_run, o_running, o_beat_idx, o_beep, o_accent
    );

    modport slave (
        input  i_start_stop, i_tempo_up, i_tempo_down, i_beats_per_bar, i_beat_tick,
        output o_bpm_out, o_div_run, o_running, o_beat_idx, o_beep, o_accent
    );

endinterface

// File: rtl/metronome_sequencer_beep.sv
// rtl/metronome_sequencer_beep.sv - retriggerable beep/accent pulse stretcher
module beep_pulse_gen #(
    parameter int LEN = 2500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_trig,
    input  logic i_accent,
    input  logic i_clear,
    output logic o_beep,
    output logic o_accent
);

    localparam int W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [W-1:0] LOAD = W'(LEN - 1);

    logic [W-1:0] r_cnt;
    logic         r_active;
    logic         r_accent;

    // The counter runs LOAD..0 with r_active high, so a pulse spans exactly LEN cycles;
    // a retrigger simply reloads, keeping the pulse contiguous.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_accent <= 1'b0;
        end else if (i_clear) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_accent <= 1'b0;
        end else if (i_trig) begin
            r_cnt    <= LOAD;
            r_active <= 1'b1;
            r_accent <= i_accent;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                r_active <= 1'b0;
                r_accent <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_beep   = r_active;
    assign o_accent = r_accent;

endmodule

// File: rtl/metronome_sequencer.sv
// rtl/metronome_sequencer.sv - run/stop FSM, tempo register and bar position for the metronome
module metronome_sequencer
    import metronome_pkg::*;
#(
    parameter bpm_t BPM_MIN     = metronome_pkg::BPM_MIN,
    parameter bpm_t BPM_MAX     = metronome_pkg::BPM_MAX,
    parameter bpm_t BPM_DEFAULT = metronome_pkg::BPM_DEFAULT,
    parameter int   BEEP_LEN    = 2500000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    metronome_sequencer_if.slave bus
);

    state_t     r_state;
    state_t     w_next_state;
    bpm_t       r_bpm_pend;
    bpm_t       r_bpm_out;
    logic [3:0] r_bar_len;
    logic [3:0] r_beat_idx;
    logic       r_div_run;
    logic       r_running;

    logic       w_start;
    logic       w_stop;
    logic       w_beat;
    logic       w_wrap;
    logic       w_beep;
    logic       w_accent;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.i_start_stop) w_next_state = START;
            START:   w_next_state = RUN;
            RUN:     if (bus.i_start_stop) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Stop takes priority over a coincident beat, so no beat is emitted on the stop cycle.
    assign w_start = (r_state == IDLE) && bus.i_start_stop;
    assign w_stop  = (r_state == RUN) && bus.i_start_stop;
    assign w_beat  = (r_state == RUN) && bus.i_beat_tick && !bus.i_start_stop;
    assign w_wrap  = (r_beat_idx == r_bar_len - 4'd1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bpm_pend <= BPM_DEFAULT;
        end else if (bus.i_tempo_up && !bus.i_tempo_down && (r_bpm_pend < BPM_MAX)) begin
            r_bpm_pend <= r_bpm_pend + 8'd1;
        end else if (bus.i_tempo_down && !bus.i_tempo_up && (r_bpm_pend > BPM_MIN)) begin
            r_bpm_pend <= r_bpm_pend - 8'd1;
        end
    end

    // While running, the divider only sees a new tempo on a beat boundary.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bpm_out <= BPM_DEFAULT;
        end else if ((r_state == IDLE) || (r_state == START) || w_beat) begin
            r_bpm_out <= r_bpm_pend;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bar_len  <= 4'd1;
            r_beat_idx <= 4'd0;
        end else if (w_start) begin
            r_bar_len  <= bar_len_of(bus.i_beats_per_bar);
            r_beat_idx <= 4'd0;
        end else if (w_stop) begin
            r_beat_idx <= 4'd0;
        end else if (w_beat) begin
            if (w_wrap) begin
                r_bar_len  <= bar_len_of(bus.i_beats_per_bar);
                r_beat_idx <= 4'd0;
            end else begin
                r_beat_idx <= r_beat_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_run <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_div_run <= (w_next_state != IDLE);
            r_running <= (w_next_state != IDLE);
        end
    end

    beep_pulse_gen #(
        .LEN (BEEP_LEN)
    ) u_beep (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_trig   (w_start || w_beat),
        .i_accent (w_start || w_wrap),
        .i_clear  (w_stop),
        .o_beep   (w_beep),
        .o_accent (w_accent)
    );

    assign bus.o_bpm_out  = r_bpm_out;
    assign bus.o_div_run  = r_div_run;
    assign bus.o_running  = r_running;
    assign bus.o_beat_idx = r_beat_idx;
    assign bus.o_beep     = w_beep;
    assign bus.o_accent   = w_accent;

endmodule

// File: tb/tb_metronome_sequencer.sv
// tb/tb_metronome_sequencer.sv - directed self-checking bench for metronome_sequencer
module tb_metronome_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    metronome_sequencer_if bus ();

    metronome_sequencer #(
        .BEEP_LEN (8)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        bus.i_beat_tick = 1'b1;
        step();
        bus.i_beat_tick = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input int idx, input int acc);
        chk({tag, "_idx"}, int'(bus.o_beat_idx), idx);
        chk({tag, "_accent"}, int'(bus.o_accent), acc);
        chk({tag, "_beep"}, int'(bus.o_beep), 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_running"}, int'(bus.o_running), 0);
        chk({tag, "_div_run"}, int'(bus.o_div_run), 0);
        chk({tag, "_idx"}, int'(bus.o_beat_idx), 0);
        chk({tag, "_beep"}, int'(bus.o_beep), 0);
        chk({tag, "_accent"}, int'(bus.o_accent), 0);
    endtask

    initial begin
        int seq_a[4];
        int seq_b[6];
        seq_a = '{1, 2, 3, 0};
        seq_b = '{2, 3, 0, 1, 2, 0};

        bus.i_start_stop    = 1'b0;
        bus.i_tempo_up      = 1'b0;
        bus.i_tempo_down    = 1'b0;
        bus.i_beats_per_bar = 4'd4;
        bus.i_beat_tick     = 1'b0;

        repeat (2) step();
        chk("rst_bpm", int'(bus.o_bpm_out), 60);
        chk_idle("rst");
        rst = 1'b0;
        step();

        for (int i = 0; i < 3; i++) begin
            do_tick();
            chk("idle_tick_idx", int'(bus.o_beat_idx), 0);
            chk("idle_tick_beep", int'(bus.o_beep), 0);
        end

        bus.i_start_stop = 1'b1;
        step();
        bus.i_start_stop = 1'b0;
        chk("start_running", int'(bus.o_running), 1);
        chk("start_div_run", int'(bus.o_div_run), 1);
        chk_beat("start", 0, 1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("start_beep_hold", int'(bus.o_beep), 1);
            chk("start_accent_hold", int'(bus.o_accent), 1);
        end
        step();
        chk("start_beep_end", int'(bus.o_beep), 0);
        chk("start_accent_end", int'(bus.o_accent), 0);

        for (int k = 0; k < 4; k++) begin
            do_tick();
            chk_beat("bar4", seq_a[k], (seq_a[k] == 0) ? 1 : 0);
            repeat (8) step();
        end

        bus.i_tempo_up = 1'b1;
        repeat (5) step();
        bus.i_tempo_up = 1'b0;
        chk("run_bpm_hold", int'(bus.o_bpm_out), 60);
        step();
        chk("run_bpm_hold2", int'(bus.o_bpm_out), 60);
        do_tick();
        chk("run_bpm_apply", int'(bus.o_bpm_out), 65);
        chk("run_bpm_idx", int'(bus.o_beat_idx), 1);
        repeat (8) step();

        bus.i_beats_per_bar = 4'd3;
        for (int k = 0; k < 6; k++) begin
            do_tick();
            chk_beat("bar_change", seq_b[k], (seq_b[k] == 0) ? 1 : 0);
            repeat (8) step();
        end

        do_tick();
        chk("retrig_t1", int'(bus.o_beep), 1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("retrig_gap", int'(bus.o_beep), 1);
        end
        do_tick();
        chk("retrig_t2", int'(bus.o_beep), 1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("retrig_hold", int'(bus.o_beep), 1);
        end
        step();
        chk("retrig_end", int'(bus.o_beep), 0);
        chk("retrig_idx", int'(bus.o_beat_idx), 2);

        do_tick();
        chk_beat("pre_stop", 0, 1);
        repeat (2) step();
        bus.i_start_stop = 1'b1;
        bus.i_beat_tick  = 1'b1;
        step();
        bus.i_start_stop = 1'b0;
        bus.i_beat_tick  = 1'b0;
        chk_idle("stop_tick");

        bus.i_tempo_up = 1'b1;
        repeat (200) step();
        bus.i_tempo_up = 1'b0;
        step();
        chk("idle_bpm_max", int'(bus.o_bpm_out), 240);
        bus.i_tempo_down = 1'b1;
        repeat (250) step();
        bus.i_tempo_down = 1'b0;
        step();
        chk("idle_bpm_min", int'(bus.o_bpm_out), 40);
        bus.i_tempo_up = 1'b1;
        step();
        bus.i_tempo_up = 1'b0;
        chk("idle_bpm_lag", int'(bus.o_bpm_out), 40);
        step();
        chk("idle_bpm_follow", int'(bus.o_bpm_out), 41);
        bus.i_tempo_up   = 1'b1;
        bus.i_tempo_down = 1'b1;
        step();
        bus.i_tempo_up   = 1'b0;
        bus.i_tempo_down = 1'b0;
        step();
        chk("idle_bpm_both", int'(bus.o_bpm_out), 41);

        bus.i_beats_per_bar = 4'd0;
        bus.i_start_stop = 1'b1;
        step();
        bus.i_start_stop = 1'b0;
        chk_beat("bpb0_start", 0, 1);
        chk("bpb0_bpm", int'(bus.o_bpm_out), 41);
        repeat (8) step();
        do_tick();
        chk_beat("bpb0_tick", 0, 1);
        repeat (2) step();

        rst = 1'b1;
        #1;
        chk("async_rst_bpm", int'(bus.o_bpm_out), 60);
        chk_idle("async_rst");
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
